// File: rtl/uart_rx_if.sv
// Receive-side UART bus: serial line and consumer handshake in, byte and status out.
// The slave modport is the receiver; the master modport is the line driver and consumer.
`timescale 1ns/1ps

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic                 i_rx_ack;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport slave (
    input  i_rx,
    input  i_rx_ack,
    output o_rx_data,
    output o_rx_valid,
    output o_frame_err,
    output o_overrun
  );

  modport master (
    output i_rx,
    output i_rx_ack,
    input  o_rx_data,
    input  o_rx_valid,
    input  o_frame_err,
    input  o_overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronised line, takes a 3-sample majority vote
// mid-bit and delivers each byte through a valid/ack handshake with framing and overrun flags.
`timescale 1ns/1ps

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 81
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic                 r_sync1;
  logic                 r_line;
  logic [DIV_W-1:0]     r_div;
  state_t               r_state;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [2:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_tick;
  logic                 w_vote_bit;
  logic                 w_vote_stop;
  logic                 w_sampling;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic                 w_shift_en;
  logic                 w_load;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // NOTE: the synchroniser resets to 1 (idle line) so release from reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_line  <= 1'b1;
    end else begin
      r_sync1 <= bus.i_rx;
      r_line  <= r_sync1;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // The stop-bit vote is taken on the third sample's own tick, so that sample comes straight from the line.
  assign w_vote_bit  = maj3(r_samp[0], r_samp[1], r_samp[2]);
  assign w_vote_stop = maj3(r_samp[0], r_samp[1], r_line);
  assign w_sampling  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_bit_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_line) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (w_vote_bit) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == CNT_LAST) begin
            w_shift_en = 1'b1;
            w_cnt_nxt  = '0;
            if (r_bit_idx == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is caught on time.
          if (r_tick_cnt == CNT_S2) begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = w_vote_stop ? S_IDLE : S_WAIT_HIGH;
          end else begin
            w_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_line) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp  <= 3'b111;
      r_shift <= '0;
    end else begin
      if (w_tick && w_sampling) begin
        if (r_tick_cnt == CNT_S0) r_samp[0] <= r_line;
        if (r_tick_cnt == CNT_S1) r_samp[1] <= r_line;
        if (r_tick_cnt == CNT_S2) r_samp[2] <= r_line;
      end
      if (w_shift_en) begin
        r_shift <= {w_vote_bit, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // A load wins over a same-cycle ack; an unacknowledged byte being replaced raises overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_load) begin
      r_rx_data   <= r_shift;
      r_rx_valid  <= 1'b1;
      r_frame_err <= ~w_vote_stop;
      if (r_rx_valid && !bus.i_rx_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (bus.i_rx_ack && r_rx_valid) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

  assign bus.o_rx_data   = r_rx_data;
  assign bus.o_rx_valid  = r_rx_valid;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overrun   = r_overrun;

endmodule
